// File: rtl/noc_phase_ctrl.sv
// Run-phase controller for NoC traffic experiments: sequences IDLE/WARMUP/MEASURE/DRAIN/DONE,
// gates injection, tags measured packets and counts measured injections and ejections.
module noc_phase_ctrl #(
  parameter int NODES           = 16,
  parameter int WARMUP_PACKETS  = 1000,
  parameter int MEASURE_PACKETS = 5000,
  parameter int DRAIN_PACKETS   = 3000,
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [NODES-1:0] i_inj_val,
  input  logic [NODES-1:0] i_ej_val,
  input  logic [NODES-1:0] i_ej_measured,
  output logic [2:0]       o_phase,
  output logic             o_inj_en,
  output logic             o_measure_tag,
  output logic [CNT_W-1:0] o_meas_inj,
  output logic [CNT_W-1:0] o_meas_ej,
  output logic [CNT_W-1:0] o_meas_cycles,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    MEASURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } phase_e;

  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] W_LIM  = CNT_W'(WARMUP_PACKETS);
  localparam logic [CNT_W-1:0] M_LIM  = CNT_W'(MEASURE_PACKETS);
  localparam logic [CNT_W-1:0] D_LIM  = CNT_W'(DRAIN_PACKETS);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] popcount(input logic [NODES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < NODES; k++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[k]};
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CNT_W]) begin
      return '1;
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d, drain_cyc_q, drain_cyc_d;
  logic [CNT_W-1:0] meas_inj_q, meas_inj_d, meas_ej_q, meas_ej_d, meas_cyc_q, meas_cyc_d;
  logic             drain_met_q, drain_met_d, timeout_q, timeout_d, err_q, err_d;
  logic             inj_en_q, inj_en_d, tag_q, tag_d, done_q, done_d;
  logic [CNT_W-1:0] inj_pop, ej_pop, cnt_sum;
  logic [CNT_W:0]   ej_wide;
  logic             drain_quota;

  // Next-state and next-output decode from current state, counters and strobes.
  always_comb begin
    inj_pop     = popcount(i_inj_val);
    ej_pop      = popcount(i_ej_val & i_ej_measured);
    cnt_sum     = sat_add(phase_cnt_q, inj_pop);
    ej_wide     = {1'b0, meas_ej_q} + {1'b0, ej_pop};
    drain_quota = drain_met_q || (cnt_sum >= D_LIM);
    phase_d     = phase_q;
    phase_cnt_d = cnt_sum;
    drain_cyc_d = drain_cyc_q;
    drain_met_d = drain_met_q;
    meas_inj_d  = meas_inj_q;
    meas_ej_d   = meas_ej_q;
    meas_cyc_d  = meas_cyc_q;
    timeout_d   = timeout_q;
    err_d       = err_q;

    // Over-ejection is flagged but the count still follows the network.
    if (phase_q != IDLE) begin
      meas_ej_d = sat_add(meas_ej_q, ej_pop);
      if (ej_wide > {1'b0, meas_inj_q}) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      meas_ej_d = meas_ej_q;
    end

    case (phase_q)
      IDLE, DONE: begin
        phase_cnt_d = phase_cnt_q;
        if (i_start) begin
          phase_d     = WARMUP;
          phase_cnt_d = '0;
          drain_cyc_d = '0;
          drain_met_d = 1'b0;
          meas_inj_d  = '0;
          meas_ej_d   = '0;
          meas_cyc_d  = '0;
          timeout_d   = 1'b0;
          err_d       = 1'b0;
        end else begin
          phase_d = phase_q;
        end
      end
      WARMUP: begin
        if (cnt_sum >= W_LIM) begin
          phase_d     = MEASURE;
          phase_cnt_d = '0;
        end else begin
          phase_d = WARMUP;
        end
      end
      MEASURE: begin
        meas_inj_d = sat_add(meas_inj_q, inj_pop);
        meas_cyc_d = sat_add(meas_cyc_q, ONE);
        if (cnt_sum >= M_LIM) begin
          phase_d     = DRAIN;
          phase_cnt_d = '0;
          drain_cyc_d = '0;
          drain_met_d = 1'b0;
        end else begin
          phase_d = MEASURE;
        end
      end
      DRAIN: begin
        drain_cyc_d = sat_add(drain_cyc_q, ONE);
        drain_met_d = drain_quota;
        // Completion is tested first so it wins over a simultaneous timeout.
        if (drain_quota && (meas_ej_q == meas_inj_q)) begin
          phase_d     = DONE;
          phase_cnt_d = '0;
        end else if (drain_cyc_q >= TO_LIM) begin
          phase_d     = DONE;
          phase_cnt_d = '0;
          timeout_d   = 1'b1;
        end else begin
          phase_d = DRAIN;
        end
      end
      default: begin
        phase_d = IDLE;
      end
    endcase

    inj_en_d = (phase_d == WARMUP) || (phase_d == MEASURE) || ((phase_d == DRAIN) && !drain_met_d);
    tag_d    = (phase_d == MEASURE);
    done_d   = (phase_d == DONE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= IDLE;
      phase_cnt_q <= '0;
      drain_cyc_q <= '0;
      drain_met_q <= 1'b0;
      meas_inj_q  <= '0;
      meas_ej_q   <= '0;
      meas_cyc_q  <= '0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
      inj_en_q    <= 1'b0;
      tag_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      phase_cnt_q <= phase_cnt_d;
      drain_cyc_q <= drain_cyc_d;
      drain_met_q <= drain_met_d;
      meas_inj_q  <= meas_inj_d;
      meas_ej_q   <= meas_ej_d;
      meas_cyc_q  <= meas_cyc_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      inj_en_q    <= inj_en_d;
      tag_q       <= tag_d;
      done_q      <= done_d;
    end
  end

  assign o_phase       = phase_q;
  assign o_inj_en      = inj_en_q;
  assign o_measure_tag = tag_q;
  assign o_meas_inj    = meas_inj_q;
  assign o_meas_ej     = meas_ej_q;
  assign o_meas_cycles = meas_cyc_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_noc_phase_ctrl.sv
// Directed bench for noc_phase_ctrl with NODES=4, WARMUP=8, MEASURE=16, DRAIN=8, TIMEOUT=64.
module tb_noc_phase_ctrl;

  logic        clk, reset, i_start;
  logic [3:0]  i_inj_val, i_ej_val, i_ej_measured;
  logic [2:0]  o_phase;
  logic        o_inj_en, o_measure_tag, o_done, o_timeout, o_err;
  logic [31:0] o_meas_inj, o_meas_ej, o_meas_cycles;

  int errors = 0;
  int checks = 0;

  noc_phase_ctrl #(
    .NODES(4), .WARMUP_PACKETS(8), .MEASURE_PACKETS(16), .DRAIN_PACKETS(8),
    .TIMEOUT_CYCLES(64), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .i_inj_val(i_inj_val), .i_ej_val(i_ej_val), .i_ej_measured(i_ej_measured),
    .o_phase(o_phase), .o_inj_en(o_inj_en), .o_measure_tag(o_measure_tag),
    .o_meas_inj(o_meas_inj), .o_meas_ej(o_meas_ej), .o_meas_cycles(o_meas_cycles),
    .o_done(o_done), .o_timeout(o_timeout), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [3:0] inj, ejv, ejm;
    logic [2:0] ph;
    logic       en, tag;
    int         mi, me, mc;
    logic       dn, to, er;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic [3:0] inj, input logic [3:0] ejv, input logic [3:0] ejm);
    i_start       = st;
    i_inj_val     = inj;
    i_ej_val      = ejv;
    i_ej_measured = ejm;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];
  int   n;

  initial begin
    // Nominal run: all nodes inject, measured packets eject 5 cycles later.
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 3'd1, 1'b1, 1'b0,  0,  0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 4'h0, 4'h0, 3'd1, 1'b1, 1'b0,  0,  0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 4'h0, 4'h0, 3'd2, 1'b1, 1'b1,  0,  0, 0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'h0, 3'd2, 1'b1, 1'b1,  4,  0, 1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'hF, 4'h0, 4'h0, 3'd2, 1'b1, 1'b1,  8,  0, 2, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 4'h0, 4'h0, 3'd2, 1'b1, 1'b1, 12,  0, 3, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'hF, 4'h0, 4'h0, 3'd3, 1'b1, 1'b0, 16,  0, 4, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'hF, 4'hF, 4'h0, 3'd3, 1'b1, 1'b0, 16,  0, 4, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'hF, 4'hF, 4'hF, 3'd3, 1'b0, 1'b0, 16,  4, 4, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'h0, 4'hF, 4'hF, 3'd3, 1'b0, 1'b0, 16,  8, 4, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 4'hF, 4'hF, 3'd3, 1'b0, 1'b0, 16, 12, 4, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 4'hF, 4'hF, 3'd3, 1'b0, 1'b0, 16, 16, 4, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 4'h0, 4'h0, 3'd4, 1'b0, 1'b0, 16, 16, 4, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    cyc(1'b0, 4'h0, 4'h0, 4'h0);
    cyc(1'b0, 4'h0, 4'h0, 4'h0);
    chk("reset_phase", 32'(o_phase), 32'd0);
    chk("reset_inj_en", 32'(o_inj_en), 32'd0);
    chk("reset_tag", 32'(o_measure_tag), 32'd0);
    chk("reset_counters", o_meas_inj | o_meas_ej | o_meas_cycles, 32'd0);
    chk("reset_flags", 32'({o_done, o_timeout, o_err}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].st, tbl[i].inj, tbl[i].ejv, tbl[i].ejm);
      chk($sformatf("nom%0d_phase", i), 32'(o_phase), 32'(tbl[i].ph));
      chk($sformatf("nom%0d_inj_en", i), 32'(o_inj_en), 32'(tbl[i].en));
      chk($sformatf("nom%0d_tag", i), 32'(o_measure_tag), 32'(tbl[i].tag));
      chk($sformatf("nom%0d_meas_inj", i), o_meas_inj, 32'(tbl[i].mi));
      chk($sformatf("nom%0d_meas_ej", i), o_meas_ej, 32'(tbl[i].me));
      chk($sformatf("nom%0d_meas_cycles", i), o_meas_cycles, 32'(tbl[i].mc));
      chk($sformatf("nom%0d_flags", i), 32'({o_done, o_timeout, o_err}), 32'({tbl[i].dn, tbl[i].to, tbl[i].er}));
    end

    // Restart from DONE, early measured ejection raises the error, then only 15 of 16 leave.
    cyc(1'b1, 4'h0, 4'h0, 4'h0);
    chk("restart_phase", 32'(o_phase), 32'd1);
    chk("restart_done", 32'(o_done), 32'd0);
    chk("restart_counters", o_meas_inj | o_meas_ej | o_meas_cycles, 32'd0);
    cyc(1'b0, 4'hF, 4'h1, 4'h1);
    chk("err_set", 32'(o_err), 32'd1);
    chk("err_meas_ej", o_meas_ej, 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'hF, 4'h0, 4'h0);
    chk("to_drain_entry", 32'(o_phase), 32'd3);
    chk("to_meas_inj", o_meas_inj, 32'd16);
    chk("err_sticky", 32'(o_err), 32'd1);
    n = 0;
    cyc(1'b0, 4'hF, 4'hF, 4'hF); n++;
    cyc(1'b0, 4'hF, 4'hF, 4'hF); n++;
    cyc(1'b0, 4'h0, 4'hF, 4'hF); n++;
    cyc(1'b0, 4'h0, 4'h3, 4'h3); n++;
    while (o_phase != 3'd4 && n < 200) begin
      cyc(1'b0, 4'h0, 4'h0, 4'h0);
      n++;
    end
    chk("to_drain_cycles", 32'(n), 32'd64);
    chk("to_timeout", 32'(o_timeout), 32'd1);
    chk("to_done", 32'(o_done), 32'd1);
    chk("to_meas_ej", o_meas_ej, 32'd15);
    chk("to_err_held", 32'(o_err), 32'd1);
    chk("to_inj_en", 32'(o_inj_en), 32'd0);
    cyc(1'b1, 4'h0, 4'h0, 4'h0);
    chk("restart2_phase", 32'(o_phase), 32'd1);
    chk("restart2_flags", 32'({o_done, o_timeout, o_err}), 32'd0);
    chk("restart2_meas_ej", o_meas_ej, 32'd0);

    // Reset in the middle of MEASURE with 9 measured packets.
    cyc(1'b0, 4'hF, 4'h0, 4'h0);
    cyc(1'b0, 4'hF, 4'h0, 4'h0);
    cyc(1'b0, 4'hF, 4'h0, 4'h0);
    cyc(1'b0, 4'hF, 4'h0, 4'h0);
    cyc(1'b0, 4'h1, 4'h0, 4'h0);
    chk("mid_meas_inj", o_meas_inj, 32'd9);
    chk("mid_phase", 32'(o_phase), 32'd2);
    reset = 1'b1;
    cyc(1'b0, 4'hF, 4'h0, 4'h0);
    reset = 1'b0;
    chk("abort_phase", 32'(o_phase), 32'd0);
    chk("abort_counters", o_meas_inj | o_meas_ej | o_meas_cycles, 32'd0);
    chk("abort_inj_en", 32'(o_inj_en), 32'd0);
    cyc(1'b0, 4'h0, 4'h0, 4'h0);
    chk("idle_holds", 32'(o_phase), 32'd0);
    cyc(1'b1, 4'h0, 4'h0, 4'h0);
    chk("abort_start_phase", 32'(o_phase), 32'd1);

    // Overshoot: phase_cnt reaches 7, then a full-width cycle crosses the warmup quota.
    cyc(1'b0, 4'h7, 4'h0, 4'h0);
    cyc(1'b0, 4'h3, 4'h0, 4'h0);
    cyc(1'b0, 4'h3, 4'h0, 4'h0);
    chk("ovs_still_warmup", 32'(o_phase), 32'd1);
    cyc(1'b0, 4'hF, 4'h0, 4'h0);
    chk("ovs_phase", 32'(o_phase), 32'd2);
    chk("ovs_meas_inj", o_meas_inj, 32'd0);
    chk("ovs_tag", 32'(o_measure_tag), 32'd1);
    cyc(1'b0, 4'h0, 4'h0, 4'h0);
    chk("ovs_meas_inj2", o_meas_inj, 32'd0);
    chk("ovs_meas_cycles", o_meas_cycles, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_phase_ctrl.md
Name: noc_phase_ctrl

Overview:
- Run-phase controller for NoC traffic experiments. Sequences each run through IDLE → WARMUP → MEASURE → DRAIN → DONE.
- Gates all node injection sources and tags packets injected during MEASURE.
- Counts injected and ejected measured packets. Ends the run once every measured packet has left the network, or on timeout.
- Sits beside the network: observes per-node accepted-injection and ejection strobes, and drives the traffic generators' enable and tag.

Parameters:
- NODES, 16, number of network nodes (width of the per-node strobe vectors)
- WARMUP_PACKETS, 1000, injected packets before measurement starts
- MEASURE_PACKETS, 5000, injected packets tagged as measured
- DRAIN_PACKETS, 3000, untagged packets injected after measurement
- TIMEOUT_CYCLES, 100000, DRAIN-phase cycle limit
- CNT_W, 32, width of all counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; honoured only in IDLE or DONE
- i_inj_val  in  NODES  packet accepted by network at node i this cycle
- i_ej_val  in  NODES  packet ejected at node i this cycle
- i_ej_measured  in  NODES  ejected packet at node i carries the measure tag; qualified by i_ej_val[i]
- o_phase  out  3  0 IDLE, 1 WARMUP, 2 MEASURE, 3 DRAIN, 4 DONE
- o_inj_en  out  1  traffic generators may inject
- o_measure_tag  out  1  tag value for packets created this cycle
- o_meas_inj  out  CNT_W  measured packets injected
- o_meas_ej  out  CNT_W  measured packets ejected
- o_meas_cycles  out  CNT_W  cycles spent in MEASURE
- o_done  out  1  run finished
- o_timeout  out  1  sticky; DRAIN timed out
- o_err  out  1  sticky; o_meas_ej would exceed o_meas_inj

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: o_phase=0, o_inj_en=0, o_measure_tag=0, all counters 0, o_done=0, o_timeout=0, o_err=0. Reset mid-run aborts immediately with no pending state kept.
- Output timing: all outputs are registered, Moore-style. Each decodes the current state and counters, with no combinational path from the inputs.
- inj_pop = popcount(i_inj_val). ej_pop = popcount(i_ej_val & i_ej_measured). Both are added in one cycle.
- phase_cnt: internal, CNT_W bits. Cleared on every phase entry. Accumulates inj_pop each cycle.
- Counter overflow: all counters saturate at all-ones and never wrap.
- IDLE: o_inj_en=0. On i_start, go to WARMUP next cycle and clear all counters and sticky flags.
- WARMUP: o_inj_en=1, tag=0. When phase_cnt+inj_pop ≥ WARMUP_PACKETS, go to MEASURE next cycle.
  - Packets in the crossing cycle belong to WARMUP; overshoot of up to NODES-1 is allowed.
- MEASURE: o_inj_en=1, tag=1.
  - o_meas_inj += inj_pop each cycle; o_meas_cycles += 1 each cycle.
  - Go to DRAIN when phase_cnt+inj_pop ≥ MEASURE_PACKETS. Crossing-cycle packets count as measured.
- Phase-boundary straggler: packets accepted one cycle after a phase change count toward the new phase. This covers the generators' one-cycle tag latency.
- DRAIN: tag=0. o_inj_en=1 until phase_cnt+inj_pop ≥ DRAIN_PACKETS, then o_inj_en=0 from the next cycle.
  - A drain cycle counter runs from DRAIN entry.
  - DONE condition: drain quota met and o_meas_ej == o_meas_inj. Go to DONE next cycle.
  - Timeout: drain counter reaches TIMEOUT_CYCLES first → DONE with o_timeout=1.
  - If both conditions occur in the same cycle, completion wins and o_timeout=0.
- Measured-ejection counting: o_meas_ej += ej_pop in every phase except IDLE.
  - If the add would exceed o_meas_inj, set o_err (sticky), but still add.
- DONE: o_inj_en=0, o_done=1. Counters hold. i_start restarts at WARMUP with counters cleared.
- i_start outside IDLE/DONE is ignored.

Test Plan:
(All scenarios use NODES=4, WARMUP=8, MEASURE=16, DRAIN=8, TIMEOUT=64.)
- Nominal run: i_inj_val=4'b1111 every cycle, each measured packet ejected 5 cycles after injection → WARMUP lasts 2 cycles, MEASURE 4 cycles (o_meas_cycles=4, o_meas_inj=16), o_inj_en drops after 2 DRAIN cycles, DONE with o_meas_ej=16 and o_timeout=0.
- Overshoot: during WARMUP, phase_cnt=7 with i_inj_val=4'b1111 → MEASURE next cycle; all 4 packets counted in WARMUP and o_meas_inj stays 0.
- Timeout: only 15 of 16 measured packets ejected → DONE 64 cycles after DRAIN entry, o_timeout=1, o_meas_ej=15.
- Error: i_ej_val=i_ej_measured=4'b0001 while o_meas_inj=0 → o_err=1 next cycle, o_meas_ej=1, and o_err stays 1 until restart.
- Reset mid-MEASURE: reset for 1 cycle with o_meas_inj=9 → next cycle o_phase=0, all counters 0, o_inj_en=0. Then i_start → o_phase=1 one cycle later.
- Restart and ignored start: i_start pulsed in MEASURE → no effect. i_start in DONE → WARMUP next cycle, o_done=0, o_timeout and o_err cleared.
